// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 decryption key schedule.
package aes_pkg;

    localparam int unsigned NR   = 10;
    localparam int unsigned NK   = 4;
    localparam int unsigned KW   = 128;
    localparam int unsigned IDXW = 4;

    // Round constants for rounds 1..10, stored at index round-1.
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_sub_c
);

    // Row-major table; entry 0 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x lives at bit offset (255-x)*8, and 255-x == ~x for a byte.
    always_comb begin
        o_sub_c = SBOX_TBL[{~i_byte, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-128 key expansion; streams round keys 10..0 to AddRoundKey.
module aes_dec_key_sched
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [KW-1:0]   key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic [KW-1:0]   rk_out,
    output logic [IDXW-1:0] rk_idx,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            busy
);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NR);

    logic [KW-1:0]   r_rk [0:NR];
    state_t          r_state, w_nxt_state;
    logic [IDXW-1:0] r_rnd, w_nxt_rnd;
    logic [IDXW-1:0] r_idx, w_nxt_idx;
    logic            r_key_ready, r_rk_valid, r_busy, w_nxt_valid;
    logic [KW-1:0]   r_rk_out, w_nxt_rk_out;
    logic            w_accept, w_xfer;
    logic            w_rk_we;
    logic [IDXW-1:0] w_rk_waddr;
    logic [KW-1:0]   w_rk_wdata;
    logic [KW-1:0]   w_prev, w_next_rk;
    logic [31:0]     w_rot, w_sub;
    logic [31:0]     w_w0, w_w1, w_w2, w_w3;

    assign w_accept = key_valid && r_key_ready;
    assign w_xfer   = r_rk_valid && rk_ready;

    // SubWord: four parallel S-boxes on the rotated last word.
    for (genvar g = 0; g < NK; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_sub_c(w_sub[8*g +: 8])
        );
    end

    // One round of key expansion from the previously stored round key.
    always_comb begin
        w_prev    = r_rk[r_rnd - 4'd1];
        w_rot     = {w_prev[23:0], w_prev[31:24]};
        w_w0      = w_prev[127:96] ^ w_sub ^ {RCON[r_rnd - 4'd1], 24'h0};
        w_w1      = w_prev[95:64] ^ w_w0;
        w_w2      = w_prev[63:32] ^ w_w1;
        w_w3      = w_prev[31:0]  ^ w_w2;
        w_next_rk = {w_w0, w_w1, w_w2, w_w3};
    end

    // Next-state, register-file write and stream control.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_rnd    = r_rnd;
        w_nxt_idx    = r_idx;
        w_nxt_valid  = r_rk_valid;
        w_nxt_rk_out = r_rk_out;
        w_rk_we      = 1'b0;
        w_rk_waddr   = r_rnd;
        w_rk_wdata   = w_next_rk;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rk_we     = 1'b1;
                    w_rk_waddr  = '0;
                    w_rk_wdata  = key_in;
                    w_nxt_rnd   = 4'd1;
                    w_nxt_state = EXPAND;
                end
            end
            EXPAND: begin
                w_rk_we = 1'b1;
                if (r_rnd == IDX_LAST) begin
                    w_nxt_state = SERVE;
                    w_nxt_idx   = IDX_LAST;
                end else begin
                    w_nxt_rnd = r_rnd + 4'd1;
                end
            end
            SERVE: begin
                if (w_accept) begin
                    // A new key wins over a coincident idx-10 transfer.
                    w_rk_we     = 1'b1;
                    w_rk_waddr  = '0;
                    w_rk_wdata  = key_in;
                    w_nxt_rnd   = 4'd1;
                    w_nxt_idx   = IDX_LAST;
                    w_nxt_valid = 1'b0;
                    w_nxt_state = EXPAND;
                end else if (!r_rk_valid) begin
                    // First cycle in SERVE: fetch the current key into the output register.
                    w_nxt_valid  = 1'b1;
                    w_nxt_rk_out = r_rk[r_idx];
                end else if (w_xfer) begin
                    if (r_idx == '0) begin
                        w_nxt_idx    = IDX_LAST;
                        w_nxt_rk_out = r_rk[IDX_LAST];
                    end else begin
                        w_nxt_idx    = r_idx - 4'd1;
                        w_nxt_rk_out = r_rk[r_idx - 4'd1];
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rnd       <= 4'd1;
            r_idx       <= IDX_LAST;
            r_key_ready <= 1'b1;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_rk_out    <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_rnd       <= w_nxt_rnd;
            r_idx       <= w_nxt_idx;
            r_key_ready <= (w_nxt_state == IDLE) ||
                           ((w_nxt_state == SERVE) && (w_nxt_idx == IDX_LAST));
            r_rk_valid  <= w_nxt_valid;
            r_busy      <= (w_nxt_state == EXPAND);
            r_rk_out    <= w_nxt_rk_out;
        end
    end

    // Round-key register file; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_rk_we) begin
            r_rk[w_rk_waddr] <= w_rk_wdata;
        end
    end

    assign key_ready = r_key_ready;
    assign rk_out    = r_rk_out;
    assign rk_idx    = r_idx;
    assign rk_valid  = r_rk_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for the AES-128 decryption key schedule.
module tb_aes_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] KEY1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] JUNK  = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    aes_dec_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // FIPS-197 round keys: key set 1 fully known, key set 2 at idx 0, 1, 10.
    function automatic logic [127:0] exp_rk(input int sel, input int i);
        if (sel == 1) begin
            case (i)
                0:  return KEY1;
                1:  return 128'ha0fafe1788542cb123a339392a6c7605;
                2:  return 128'hf2c295f27a96b9435935807a7359f67f;
                3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
                4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
                5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
                6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
                7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
                8:  return 128'head27321b58dbad2312bf5607f8d292f;
                9:  return 128'hac7766f319fadc2128d12941575c006e;
                default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            endcase
        end
        case (i)
            0:  return KEY2;
            1:  return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            default: return 128'h13111d7fe3944a17f307a78b4d2b30c5;
        endcase
    endfunction

    function automatic bit known(input int sel, input int i);
        return (sel == 1) || (i == 0) || (i == 1) || (i == 10);
    endfunction

    // Present a key and hold it until the accepting edge has passed.
    task automatic accept_key(input logic [127:0] k);
        int n;
        key_in    = k;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("key_ready_before_accept", 128'(key_ready), 128'(1));
        tick();
        key_valid = 1'b0;
        check_eq("busy_after_accept", 128'(busy), 128'(1));
    endtask

    task automatic wait_valid(input bit chk_lat, input int lat);
        int n;
        n = 0;
        while (!rk_valid && n < 40) begin
            tick();
            n++;
        end
        if (chk_lat) check_eq("latency", 128'(n), 128'(lat));
        else         check_eq("valid_timeout", 128'(rk_valid), 128'(1));
    endtask

    task automatic wait_idx(input int idx);
        int n;
        n = 0;
        while (int'(rk_idx) != idx && n < 40) begin
            tick();
            n++;
        end
        check_eq($sformatf("reach_idx%0d", idx), 128'(rk_idx), 128'(idx));
    endtask

    // Stream a full schedule with rk_ready high, then check the wrap.
    task automatic stream_all(input int sel);
        rk_ready = 1'b1;
        check_eq("stream_valid", 128'(rk_valid), 128'(1));
        for (int i = 10; i >= 0; i--) begin
            check_eq($sformatf("k%0d_idx%0d", sel, i), 128'(rk_idx), 128'(i));
            if (known(sel, i))
                check_eq($sformatf("k%0d_rk%0d", sel, i), rk_out, exp_rk(sel, i));
            tick();
        end
        check_eq($sformatf("k%0d_wrap_idx", sel), 128'(rk_idx), 128'(10));
        check_eq($sformatf("k%0d_wrap_rk", sel), rk_out, exp_rk(sel, 10));
    endtask

    initial begin
        logic [47:0] pat;
        int          e;
        logic        rdy;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_key_ready", 128'(key_ready), 128'(1));
        check_eq("rst_rk_valid",  128'(rk_valid),  128'(0));
        check_eq("rst_rk_idx",    128'(rk_idx),    128'(10));
        check_eq("rst_busy",      128'(busy),      128'(0));
        check_eq("rst_rk_out",    rk_out,          128'(0));
        rst = 1'b0;
        tick();

        // Key 1 with the consumer always ready.
        rk_ready = 1'b1;
        accept_key(KEY1);
        wait_valid(1'b1, 11);
        stream_all(1);

        // Key 2 accepted at idx 10 while a transfer of idx 10 is also happening.
        accept_key(KEY2);
        check_eq("k2_accept_valid_drop", 128'(rk_valid), 128'(0));
        wait_valid(1'b1, 11);
        stream_all(2);

        // Reload key 1, then stream it under a fixed backpressure pattern.
        accept_key(KEY1);
        wait_valid(1'b1, 11);
        pat = 48'hb35ce1960fa7;
        e   = 10;
        for (int c = 0; c < 48; c++) begin
            check_eq($sformatf("bp%0d_idx", c), 128'(rk_idx), 128'(e));
            check_eq($sformatf("bp%0d_rk", c),  rk_out, exp_rk(1, e));
            rdy      = pat[c];
            rk_ready = rdy;
            tick();
            if (rdy) e = (e == 0) ? 10 : e - 1;
        end

        // key_valid during EXPAND is ignored.
        rk_ready = 1'b1;
        wait_idx(10);
        accept_key(KEY2);
        key_in    = JUNK;
        key_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("exp_ignore%0d", c), 128'(key_ready), 128'(0));
            tick();
        end
        key_valid = 1'b0;
        wait_valid(1'b0, 0);
        check_eq("k2_after_junk_rk10", rk_out, exp_rk(2, 10));

        // key_valid in SERVE at idx 5 is ignored and the stream holds.
        wait_idx(5);
        rk_ready  = 1'b0;
        key_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq($sformatf("srv_ignore%0d_ready", c), 128'(key_ready), 128'(0));
            check_eq($sformatf("srv_ignore%0d_idx", c),   128'(rk_idx),    128'(5));
            check_eq($sformatf("srv_ignore%0d_valid", c), 128'(rk_valid),  128'(1));
        end
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        tick();
        check_eq("srv_resume_idx4", 128'(rk_idx), 128'(4));
        wait_idx(10);
        accept_key(KEY1);
        wait_valid(1'b1, 11);
        stream_all(1);

        // Reset in the middle of expansion.
        accept_key(KEY2);
        for (int c = 0; c < 4; c++) tick();
        check_eq("mid_expand_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_key_ready", 128'(key_ready), 128'(1));
        check_eq("mrst_rk_valid",  128'(rk_valid),  128'(0));
        check_eq("mrst_busy",      128'(busy),      128'(0));
        check_eq("mrst_rk_idx",    128'(rk_idx),    128'(10));
        check_eq("mrst_rk_out",    rk_out,          128'(0));
        accept_key(KEY1);
        wait_valid(1'b1, 11);
        stream_all(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
